// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and helpers for the sequential multiplier
package mul_pkg;

  localparam int MUL_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's-complement negate when neg is set. Callers keep the low bits they
  // need; the most negative value maps to itself, which is its correct
  // unsigned magnitude.
  function automatic logic [63:0] abs_w(input logic [63:0] x, input logic neg);
    return neg ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/mul_seq_ctl.sv
// rtl/mul_seq_ctl.sv - radix-2 shift-add multiplier with start/busy/done handshake
module mul_seq_ctl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   c
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t               state;
  logic [WIDTH-1:0]     ma;
  logic [WIDTH-1:0]     mb;
  logic [2*WIDTH-1:0]   acc;
  logic                 neg;
  logic [CNT_W-1:0]     cnt;

  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       sum;

  // Operand magnitudes for the start cycle and the carry-preserving partial sum.
  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];
    a_mag = WIDTH'(abs_w(64'(a), a_neg));
    b_mag = WIDTH'(abs_w(64'(b), b_neg));
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, ma};
  end

  // Controller and datapath: latch on start, WIDTH shift-add steps, then sign fix-up.
  // The multiplier register shifts right each step, so its bit 0 is always
  // the multiplier bit selected by the current iteration count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      c     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ma    <= a_mag;
            mb    <= b_mag;
            neg   <= a_neg ^ b_neg;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (mb[0]) begin
            // Carry out of the top half becomes the new MSB after the shift.
            acc <= {sum, acc[WIDTH-1:1]};
          end else begin
            acc <= acc >> 1;
          end
          mb  <= mb >> 1;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          c     <= neg ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctl.sv
// tb/tb_mul_seq_ctl.sv - directed and random checks of mul_seq_ctl at widths 8, 16 and 32
module tb_mul_seq_ctl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;
  logic        start16, sgn16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] c16;
  logic        start32, sgn32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] c32;

  mul_seq_ctl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .c(c8)
  );
  mul_seq_ctl #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sgn16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .c(c16)
  );
  mul_seq_ctl #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(sgn32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .c(c32)
  );

  int checks = 0;
  int errors = 0;
  int pend8 = 0, pend16 = 0, pend32 = 0;
  int spurious = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int w, input logic st, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
    case (w)
      8:       begin start8 = st;  sgn8 = s;  a8 = a[7:0];   b8 = b[7:0];   end
      16:      begin start16 = st; sgn16 = s; a16 = a[15:0]; b16 = b[15:0]; end
      default: begin start32 = st; sgn32 = s; a32 = a;       b32 = b;       end
    endcase
  endtask

  function automatic logic get_busy(input int w);
    case (w)
      8:       return busy8;
      16:      return busy16;
      default: return busy32;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      8:       return done8;
      16:      return done16;
      default: return done32;
    endcase
  endfunction

  function automatic logic [63:0] get_c(input int w);
    case (w)
      8:       return {48'd0, c8};
      16:      return {32'd0, c16};
      default: return c32;
    endcase
  endfunction

  // Reference product: extend to 64 bits, multiply modulo 2^64, keep 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    logic [63:0] ea, eb, hi, p, m;
    hi = ~((64'd1 << w) - 64'd1);
    ea = {32'd0, a};
    eb = {32'd0, b};
    if (s && a[w-1]) ea = ea | hi;
    if (s && b[w-1]) eb = eb | hi;
    p = ea * eb;
    m = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return p & m;
  endfunction

  // One operation: start for one cycle, then wait (bounded) for done.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic s, output logic [63:0] res, output int lat,
                        output int busy_cnt);
    @(negedge clk);
    set_in(w, 1'b1, s, a, b);
    @(posedge clk);
    @(negedge clk);
    busy_cnt = int'(get_busy(w));
    set_in(w, 1'b0, s, a, b);
    lat = -1;
    res = '0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_busy(w)) busy_cnt++;
      if (get_done(w)) begin
        lat = k;
        res = get_c(w);
        break;
      end
    end
  endtask

  // Count accepted starts per unit.
  always @(posedge clk) begin
    if (!rst_n) begin
      pend8 = 0; pend16 = 0; pend32 = 0;
    end else begin
      if (start8 && !busy8) pend8++;
      if (start16 && !busy16) pend16++;
      if (start32 && !busy32) pend32++;
    end
  end

  // Every done must consume an earlier accepted start.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done8)  begin if (pend8 == 0)  spurious++; else pend8--;  end
      if (done16) begin if (pend16 == 0) spurious++; else pend16--; end
      if (done32) begin if (pend32 == 0) spurious++; else pend32--; end
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] c;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [63:0] res;
    int lat, bcnt;
    int t[$];
    logic [15:0] cv[$];

    tbl[0]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[1]  = '{8'hFD, 8'h07, 1'b1, 16'hFFEB};
    tbl[2]  = '{8'h00, 8'h85, 1'b1, 16'h0000};
    tbl[3]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[4]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[5]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    tbl[6]  = '{8'h03, 8'h05, 1'b0, 16'h000F};
    tbl[7]  = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    tbl[8]  = '{8'h0C, 8'hF6, 1'b1, 16'hFF88};
    tbl[9]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
    tbl[10] = '{8'hFF, 8'h00, 1'b1, 16'h0000};

    set_in(8, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(16, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(32, 1'b0, 1'b0, 32'd0, 32'd0);

    #12;
    chk("reset_busy8", {63'd0, busy8}, 64'd0);
    chk("reset_done8", {63'd0, done8}, 64'd0);
    chk("reset_c8", {48'd0, c8}, 64'd0);
    chk("reset_busy32", {63'd0, busy32}, 64'd0);
    chk("reset_done32", {63'd0, done32}, 64'd0);
    chk("reset_c32", c32, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(8, {24'd0, tbl[i].a}, {24'd0, tbl[i].b}, tbl[i].s, res, lat, bcnt);
      chk($sformatf("tbl%0d_c", i), res, {48'd0, tbl[i].c});
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd9);
    end

    run_op(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat, bcnt);
    chk("max32_c", res, 64'hFFFF_FFFE_0000_0001);
    chk("max32_lat", 64'(lat), 64'd33);
    chk("max32_busy", 64'(bcnt), 64'd33);

    // Start held high: results every 10 cycles, operand change mid-RUN.
    @(negedge clk);
    set_in(8, 1'b1, 1'b0, 32'd3, 32'd5);
    for (int i = 1; i <= 70 && t.size() < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done8) begin
        t.push_back(i);
        cv.push_back(c8);
      end
      if (t.size() == 3 && i == t[2] + 3) a8 = 8'd9;
    end
    start8 = 1'b0;
    chk("b2b_count", 64'(t.size()), 64'd5);
    if (t.size() == 5) begin
      chk("b2b_first", 64'(t[0]), 64'd10);
      for (int k = 1; k < 5; k++) chk($sformatf("b2b_gap%0d", k), 64'(t[k] - t[k-1]), 64'd10);
      for (int k = 0; k < 4; k++) chk($sformatf("b2b_c%0d", k), {48'd0, cv[k]}, 64'd15);
      chk("b2b_c4", {48'd0, cv[4]}, 64'd45);
    end

    // Reset in the middle of a W=16 operation.
    run_op(16, 32'h1234, 32'h0101, 1'b0, res, lat, bcnt);
    chk("pre_rst_c16", res, 64'h0012_4634);
    @(negedge clk);
    set_in(16, 1'b1, 1'b0, 32'd7, 32'd9);
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy16", {63'd0, busy16}, 64'd0);
    chk("rst_done16", {63'd0, done16}, 64'd0);
    chk("rst_c16", {32'd0, c16}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16, 32'd1000, 32'd1000, 1'b0, res, lat, bcnt);
    chk("post_rst_c16", res, 64'h000F_4240);
    chk("post_rst_lat16", 64'(lat), 64'd17);

    // Random regression across widths, with corner operands mixed in.
    for (int n = 0; n < 2000; n++) begin
      int w;
      logic [31:0] mask, ra, rb;
      logic rs;
      w = 8 << $urandom_range(0, 2);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      ra = $urandom & mask;
      rb = $urandom & mask;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       ra = 32'd0;
          1:       ra = mask;
          default: ra = 32'd1 << (w - 1);
        endcase
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       rb = 32'd0;
          1:       rb = mask;
          default: rb = 32'd1 << (w - 1);
        endcase
      end
      rs = 1'($urandom_range(0, 1));
      run_op(w, ra, rb, rs, res, lat, bcnt);
      chk($sformatf("rand_w%0d_a%0h_b%0h_s%0d", w, ra, rb, rs), res, ref_mul(w, ra, rb, rs));
    end

    repeat (3) @(negedge clk);
    chk("spurious_done", 64'(spurious), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
